// File: rtl/alu_control_md.sv
// ALU control with an iterative multiply/divide sequencer for the MIPS datapath.
// Decodes aluOp/funcCode into the ALU operation and raises a flag for codes it
// cannot decode. Runs mult/multu/div/divu over WIDTH iterations, keeps the
// HI/LO registers, and handles mfhi/mflo/mthi/mtlo.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   valid           the instruction in the decode/execute slot is real
//   aluOp, funcCode from main control / instruction[5:0]
//   rs_val, rt_val  operands (dividend/multiplicand/mt source, divisor/multiplier)
//   aluSignal       ALU operation (combinational)
//   illegal         undecodable code while valid (combinational)
//   resultSel       writeback source: 00 ALU, 01 HI, 10 LO (combinational)
//   stall           hold PC and the current instruction (combinational)
//   mdBusy          sequencer running (registered)
//   hi, lo          HI/LO registers
module alu_control_md #(
  parameter int WIDTH   = 32,
  parameter bit EXT_OPS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [1:0]       aluOp,
  input  logic [5:0]       funcCode,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       aluSignal,
  output logic             illegal,
  output logic [1:0]       resultSel,
  output logic             stall,
  output logic             mdBusy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_d;

  logic bad, md_fn, op_start, op_mthi, op_mtlo, op_signed, issue;

  always_comb begin
    aluSignal = 4'b1111;
    bad       = 1'b0;
    md_fn     = 1'b0;
    resultSel = 2'b00;
    op_start  = 1'b0;
    op_mthi   = 1'b0;
    op_mtlo   = 1'b0;
    case (aluOp)
      2'b00: aluSignal = 4'b0010;
      2'b01: aluSignal = 4'b0110;
      2'b11: aluSignal = 4'b0001;
      default: begin
        if (EXT_OPS) begin
          case (funcCode)
            6'b100000, 6'b100001: aluSignal = 4'b0010;
            6'b100010, 6'b100011: aluSignal = 4'b0110;
            6'b100100: aluSignal = 4'b0000;
            6'b100101: aluSignal = 4'b0001;
            6'b100110: aluSignal = 4'b0011;
            6'b100111: aluSignal = 4'b1100;
            6'b101010: aluSignal = 4'b0111;
            6'b101011: aluSignal = 4'b1000;
            6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
              aluSignal = 4'b0010;
              md_fn     = 1'b1;
              op_start  = 1'b1;
            end
            6'b010000: begin
              aluSignal = 4'b0010;
              md_fn     = 1'b1;
              resultSel = 2'b01;
            end
            6'b010001: begin
              aluSignal = 4'b0010;
              md_fn     = 1'b1;
              op_mthi   = 1'b1;
            end
            6'b010010: begin
              aluSignal = 4'b0010;
              md_fn     = 1'b1;
              resultSel = 2'b10;
            end
            6'b010011: begin
              aluSignal = 4'b0010;
              md_fn     = 1'b1;
              op_mtlo   = 1'b1;
            end
            default: bad = 1'b1;
          endcase
        end else begin
          case (funcCode)
            6'b100000: aluSignal = 4'b0010;
            6'b100010: aluSignal = 4'b0110;
            6'b100100: aluSignal = 4'b0000;
            6'b101010: aluSignal = 4'b0111;
            default:   bad = 1'b1;
          endcase
        end
      end
    endcase
  end

  // funct bit0 = 0 selects the signed variant, bit1 = 1 selects divide
  assign op_signed = ~funcCode[0];
  assign illegal   = valid & bad;
  assign stall     = valid & mdBusy & md_fn;
  assign issue     = valid & op_start & ~stall & (state == IDLE);

  // Shared datapath: acc holds the product high half / partial remainder,
  // qreg holds the multiplier / dividend-then-quotient, mcand the other operand.
  logic [WIDTH-1:0]   acc, qreg, mcand, abs_rs, abs_rt, quo, rem;
  logic [CW-1:0]      count;
  logic               is_div, neg_q, neg_r, div0;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    abs_rs    = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    abs_rt    = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    mul_sum   = {1'b0, acc} + {1'b0, (qreg[0] ? mcand : '0)};
    div_shift = {acc, qreg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    prod      = neg_q ? -{acc, qreg} : {acc, qreg};
    quo       = div0 ? '1 : (neg_q ? -qreg : qreg);
    rem       = neg_r ? -acc : acc;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (issue) state_d = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mdBusy <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      qreg   <= '0;
      mcand  <= '0;
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      mdBusy <= (state_d != IDLE);
      case (state)
        IDLE: begin
          if (issue) begin
            count  <= '0;
            acc    <= '0;
            is_div <= funcCode[1];
            div0   <= funcCode[1] && (rt_val == '0);
            neg_q  <= op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_r  <= op_signed & rs_val[WIDTH-1];
            if (funcCode[1]) begin
              qreg  <= abs_rs;
              mcand <= abs_rt;
            end else begin
              qreg  <= abs_rt;
              mcand <= abs_rs;
            end
          end else if (valid && op_mthi) begin
            hi <= rs_val;
          end else if (valid && op_mtlo) begin
            lo <= rs_val;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (is_div) begin
            // restoring step: keep the subtraction only when it did not borrow
            if (!div_diff[WIDTH]) begin
              acc  <= div_diff[WIDTH-1:0];
              qreg <= {qreg[WIDTH-2:0], 1'b1};
            end else begin
              acc  <= div_shift[WIDTH-1:0];
              qreg <= {qreg[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc  <= mul_sum[WIDTH:1];
            qreg <= {mul_sum[0], qreg[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            {hi, lo} <= prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
Next-generation ALU control for the MIPS datapath.
- Decodes aluOp/funcCode into the 4-bit ALU operation over an extended R-type set.
- Flags undecodable codes instead of driving Z.
- Adds a WIDTH-parametrised iterative multiply/divide sequencer with HI/LO registers, mfhi/mflo/mthi/mtlo support and a stall output for hazards.
- Sits beside the main control unit; its outputs feed the ALU, the writeback result mux and the PC-hold logic.

Parameters:
WIDTH, 32, datapath width; even, >= 4.
EXT_OPS, 1, 1 = full funct table; 0 = legacy table only (add/sub/and/slt); all other R-type codes illegal.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid  in  1  instruction in the decode/execute slot is real
aluOp  in  2  from main control
funcCode  in  6  instruction[5:0]
rs_val  in  WIDTH  rs operand (dividend / multiplicand / mt source)
rt_val  in  WIDTH  rt operand (divisor / multiplier)
aluSignal  out  4  ALU operation, combinational
illegal  out  1  undecodable aluOp/funcCode while valid, combinational
resultSel  out  2  writeback source: 00 ALU, 01 HI, 10 LO, combinational
stall  out  1  hold PC and the current instruction, combinational
mdBusy  out  1  sequencer running, registered
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- aluOp decode:
  - 00 -> 0010 (lw/sw/addi).
  - 01 -> 0110 (beq).
  - 11 -> 0001 (ori).
  - 10 -> funct table.
- Funct table, EXT_OPS=1:
  - 100000/100001 -> 0010; 100010/100011 -> 0110.
  - 100100 -> 0000; 100101 -> 0001; 100110 -> 0011; 100111 -> 1100.
  - 101010 -> 0111; 101011 -> 1000.
  - 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo: aluSignal = 0010, illegal = 0.
  - Any other code -> aluSignal = 1111, illegal = valid.
- resultSel = 01 for mfhi, 10 for mflo, 00 otherwise.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - valid & mult/div op & !stall -> latch |rs|, |rt| (signed ops take magnitude), record sign flags; count <= 0; -> RUN.
  - mthi/mtlo -> hi/lo <= rs_val at that edge.
- RUN:
  - One iteration per cycle: shift-add multiply or restoring divide.
  - After exactly WIDTH iterations -> FIX.
- FIX:
  - Apply sign corrections.
  - Multiply: negate the 2*WIDTH product if the signs differ.
  - Divide: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write hi/lo; -> IDLE.
- Latency: mdBusy is high from the edge after issue for exactly WIDTH+1 cycles (RUN+FIX). hi/lo are updated at the FIX edge and are visible the cycle mdBusy falls.
- Result mapping: mult → hi:lo = 2*WIDTH product. div → lo = quotient, hi = remainder.
- Divide by zero: lo = all ones, hi = rs_val. No exception.
- Signed MIN / -1: lo = MIN, hi = 0.
- stall = valid & mdBusy & (funct is mult/div/mf/mt) & aluOp==10. The issuing instruction itself never stalls. Non-MD instructions proceed while busy.
- mthi/mtlo while busy are stalled, never lost or merged.
- reset:
  - State IDLE, mdBusy = 0, hi = lo = 0, counters 0.
  - Reset during RUN/FIX aborts the operation; no partial hi/lo write.
  - Reset dominates a simultaneous issue.
- Combinational outputs depend only on inputs and mdBusy; no latches; no X/Z on any output after reset.

Test Plan:
- Decode sweep: every aluOp × all 64 funct, EXT_OPS=1 and 0 -> aluSignal/illegal match the table. Legacy mode: 100101 gives aluSignal=1111, illegal=1.
- mult rs=0xFFFFFFFD (-3), rt=7, WIDTH=32 -> mdBusy high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. multu with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- divu 100/7 -> lo=14, hi=2. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/-1 -> lo=0x80000000, hi=0.
- div 5/0 -> lo=0xFFFFFFFF, hi=5.
- mflo issued 3 cycles after mult -> stall=1 until mdBusy falls, then resultSel=10 with the new lo. An add issued while busy -> stall=0.
- mthi 0x1234 in IDLE -> hi=0x1234 next cycle. Reset asserted mid-RUN -> mdBusy=0, hi=lo=0 next cycle, and a following mult runs the full 33 cycles.
